instr_issue_buffer: RTL and testbench
=====================================

# instr_issue_buffer

Instruction issue buffer sitting directly upstream of the low-power control unit. It accepts opcodes from the fetch stage over a valid/ready handshake, queues them in a small FIFO, and presents them one at a time as `opcode`/`valid` to the control unit. It holds the presented opcode stable while empty so that decode inputs do not toggle. It raises an `idle` flag after a programmable number of empty cycles, for use by clock gating.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `OPCODE_W`, default 3: opcode width; matches the control unit opcode.
- `IDLE_CYCLES`, default 8: consecutive empty cycles before `idle` asserts; ≥1.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch presents an opcode.
- `in_opcode`  in  OPCODE_W  opcode from fetch.
- `in_ready`  out  1  buffer can accept a push this cycle.
- `out_valid`  out  1  drives the control unit `valid`.
- `out_opcode`  out  OPCODE_W  drives the control unit `opcode`.
- `out_ready`  in  1  downstream consumes the head this cycle.
- `flush`  in  1  discard all queued opcodes.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `idle`  out  1  buffer has been empty and unrequested for IDLE_CYCLES cycles.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count < DEPTH) && !flush`. It has no combinational path from `out_ready`.
- `out_valid = (count != 0)`, registered.
- `out_opcode` is a register:
  - When `count > 0`, it equals the FIFO head.
  - When the FIFO drains, it holds the last popped opcode.
  - It changes only when the head changes.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Count arithmetic never over- or underflows.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, the head advances, and the new entry is written at the tail.
- Push into an empty buffer: the entry becomes the head and `out_opcode` updates on the same edge.
- Pop and push on the same edge when count == 1: the new entry becomes the head and count stays 1.
- `flush` is synchronous:
  - Rising edge with `flush` = 1: count = 0, pointers = 0, `out_valid` = 0.
  - `out_opcode` holds its value.
  - A push in the same cycle is blocked (`in_ready` = 0). A pop in the same cycle is ignored.
- Idle counter:
  - Increments each cycle that `count == 0 && !in_valid`, saturating at IDLE_CYCLES.
  - Clears to 0 on any cycle with `count != 0` or `in_valid`.
- `idle = (idle_cnt == IDLE_CYCLES) && !in_valid`. The combinational deassert on `in_valid` lets gating wake in the same cycle.
- Reset (asynchronous, any time, including mid-transfer):
  - count = 0, pointers = 0, idle_cnt = 0.
  - `out_valid` = 0, `out_opcode` = 0 (NOP).
  - Storage contents are don't-care.
  - `in_ready` = 1 once `rst` deasserts; it is 0 while `rst` is high.

## Timing
- Latency: an opcode pushed at edge t is on `out_opcode`, with `out_valid` = 1, immediately after edge t.
- Throughput: one push and one pop per cycle sustained.
- Full (count == DEPTH):
  - `in_ready` = 0 even if `out_ready` = 1.
  - A pop at edge t raises `in_ready` after edge t.
- Empty: `out_ready` is ignored and no count change occurs.
- After reset release, `idle` first asserts IDLE_CYCLES edges later, provided `in_valid` stays low.
- Flush at edge t: `in_ready` returns to 1 in cycle t+1 if `flush` is deasserted.

## Test plan
- Reset, then push 0b001, 0b010, 0b011 back-to-back with `out_ready` = 0 -> count = 3, `out_opcode` = 001, `out_valid` = 1. Then `out_ready` = 1 for 3 cycles -> opcodes 001, 010, 011 in order, then `out_valid` = 0 with `out_opcode` held at 011.
- Fill to DEPTH = 4 (opcodes 001..100) -> `in_ready` = 0. A push attempt of 111 is not accepted. One pop -> `in_ready` = 1 the next cycle. The 111 is then accepted and later emerges after 100.
- Continuous push of an incrementing opcode with `out_ready` = 1 for 10 cycles -> count stays 1, one opcode is emitted per cycle in order, pointers wrap with no loss or duplication.
- Queue 2 entries, assert `flush` for 1 cycle together with `in_valid` = 1 -> count = 0 and `out_valid` = 0 next cycle, the flush-cycle opcode is not stored, `out_opcode` is unchanged.
- Idle check: after reset with `in_valid` = 0 -> `idle` = 1 exactly 8 cycles after reset release. Raising `in_valid` -> `idle` = 0 in the same cycle, and idle_cnt restarts after the buffer drains.
- Assert `rst` mid-stream with 3 entries queued -> `out_valid` = 0, `out_opcode` = 000, count = 0 immediately (asynchronous). After release, the first new push emerges as the head.

Source files
------------

// File: rtl/instr_issue_buffer_if.sv
// Handshake bundle between fetch, the issue buffer and the control unit.
//   in_valid / in_opcode / in_ready    : fetch-side push handshake
//   out_valid / out_opcode / out_ready : control-unit-side pop handshake
//   flush                              : discard every queued opcode
// slave  : the issue buffer
// master : the environment driving it (fetch + control unit)
interface instr_issue_buffer_if #(
    parameter int OPCODE_W = 3
);
    logic                in_valid;
    logic [OPCODE_W-1:0] in_opcode;
    logic                in_ready;
    logic                out_valid;
    logic [OPCODE_W-1:0] out_opcode;
    logic                out_ready;
    logic                flush;

    modport slave (
        input  in_valid, in_opcode, out_ready, flush,
        output in_ready, out_valid, out_opcode
    );

    modport master (
        output in_valid, in_opcode, out_ready, flush,
        input  in_ready, out_valid, out_opcode
    );
endinterface

// File: rtl/instr_issue_buffer.sv
// Instruction issue buffer: small FIFO between fetch and the low-power
// control unit. The head is presented on a registered out_opcode that holds
// its last value while empty so decode inputs stay quiet, and idle flags a
// run of IDLE_CYCLES empty cycles for clock gating.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : handshake bundle (slave side)
//   count    : current occupancy
//   idle     : empty and unrequested for IDLE_CYCLES cycles
module instr_issue_buffer #(
    parameter int DEPTH       = 4,
    parameter int OPCODE_W    = 3,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_issue_buffer_if.slave        bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       idle
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    logic [OPCODE_W-1:0] mem [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr_nxt;
    logic [IW-1:0]       idle_cnt;
    logic                out_valid_q;
    logic [OPCODE_W-1:0] out_opcode_q;
    logic                push;
    logic                pop;

    // in_ready depends only on local state, flush and rst, never on out_ready.
    assign bus.in_ready   = !rst && !bus.flush && (count < CW'(DEPTH));
    assign bus.out_valid  = out_valid_q;
    assign bus.out_opcode = out_opcode_q;

    assign push       = bus.in_valid && bus.in_ready;
    assign pop        = out_valid_q && bus.out_ready && !bus.flush;
    assign rd_ptr_nxt = rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_opcode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
        end else if (bus.flush) begin
            // out_opcode deliberately holds across a flush.
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10: begin
                    count       <= count + CW'(1);
                    out_valid_q <= 1'b1;
                end
                2'b01: begin
                    count       <= count - CW'(1);
                    out_valid_q <= (count != CW'(1));
                end
                default: ;
            endcase
            // The new entry bypasses storage when it becomes the head on the
            // same edge it is written (empty, or sole entry being popped).
            if (push && ((count == '0) || (pop && count == CW'(1)))) begin
                out_opcode_q <= bus.in_opcode;
            end else if (pop && count > CW'(1)) begin
                out_opcode_q <= mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (count == '0 && !bus.in_valid) begin
            if (idle_cnt != IW'(IDLE_CYCLES)) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end else begin
            idle_cnt <= '0;
        end
    end

    // Combinational release on in_valid lets gating wake in the same cycle.
    assign idle = (idle_cnt == IW'(IDLE_CYCLES)) && !bus.in_valid;

endmodule

// File: tb/tb_instr_issue_buffer.sv
module tb_instr_issue_buffer;
    logic       clk;
    logic       rst;
    logic [2:0] count;
    logic       idle;
    int         checks;
    int         errors;

    instr_issue_buffer_if #(.OPCODE_W(3)) bus ();

    instr_issue_buffer #(
        .DEPTH(4),
        .OPCODE_W(3),
        .IDLE_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .count(count),
        .idle (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [2:0] op);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 3'b000;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #3;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_opcode !== 3'b000 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b opcode=%b count=%0d, want 0 000 0",
                     bus.out_valid, bus.out_opcode, count);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    // Entered right after reset release, with in_valid low.
    task automatic test_idle();
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (idle !== 1'b0) begin
            errors++;
            $display("FAIL idle_early: got %b want 0 after 7 edges", idle);
        end
        tick();
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL idle_assert: got %b want 1 after 8 edges", idle);
        end
        bus.in_valid  = 1'b1;
        bus.in_opcode = 3'b101;
        #1;
        checks++;
        if (idle !== 1'b0) begin
            errors++;
            $display("FAIL idle_wake: got %b want 0 with in_valid high", idle);
        end
        tick();
        bus.in_valid  = 1'b0;
        checks++;
        if (count !== 3'd1 || bus.out_opcode !== 3'b101 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL idle_push: count=%0d opcode=%b valid=%b, want 1 101 1",
                     count, bus.out_opcode, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (idle !== 1'b0) begin
            errors++;
            $display("FAIL idle_restart_early: got %b want 0", idle);
        end
        tick();
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL idle_restart: got %b want 1", idle);
        end
    endtask

    task automatic test_fifo_order();
        logic [2:0] exp [3];
        exp[0] = 3'b001;
        exp[1] = 3'b010;
        exp[2] = 3'b011;
        for (int i = 0; i < 3; i++) push_one(exp[i]);
        checks++;
        if (count !== 3'd3 || bus.out_opcode !== 3'b001 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL order_fill: count=%0d opcode=%b valid=%b, want 3 001 1",
                     count, bus.out_opcode, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_opcode !== exp[i] || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL order_pop%0d: opcode=%b valid=%b, want %b 1",
                         i, bus.out_opcode, bus.out_valid, exp[i]);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_opcode !== 3'b011 || count !== 3'd0) begin
            errors++;
            $display("FAIL order_drain: valid=%b opcode=%b count=%0d, want 0 011 0",
                     bus.out_valid, bus.out_opcode, count);
        end
        // Empty buffer ignores out_ready.
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || bus.out_opcode !== 3'b011) begin
            errors++;
            $display("FAIL empty_pop: count=%0d opcode=%b, want 0 011", count, bus.out_opcode);
        end
    endtask

    task automatic test_full();
        logic [2:0] exp [4];
        exp[0] = 3'b010;
        exp[1] = 3'b011;
        exp[2] = 3'b100;
        exp[3] = 3'b111;
        for (int i = 1; i <= 4; i++) push_one(3'(i));
        checks++;
        if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: count=%0d in_ready=%b, want 4 0", count, bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.in_opcode = 3'b111;
        tick();
        checks++;
        if (count !== 3'd4 || bus.out_opcode !== 3'b001) begin
            errors++;
            $display("FAIL full_reject: count=%0d head=%b, want 4 001", count, bus.out_opcode);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_no_bypass: in_ready=%b want 0", bus.in_ready);
        end
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 3'd3 || bus.in_ready !== 1'b1 || bus.out_opcode !== 3'b010) begin
            errors++;
            $display("FAIL full_pop: count=%0d in_ready=%b head=%b, want 3 1 010",
                     count, bus.in_ready, bus.out_opcode);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full_accept: count=%0d want 4", count);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_opcode !== exp[i] || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_drain%0d: opcode=%b valid=%b, want %b 1",
                         i, bus.out_opcode, bus.out_valid, exp[i]);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: count=%0d valid=%b, want 0 0", count, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_opcode = 3'd1;
        tick();
        for (int k = 1; k < 10; k++) begin
            bus.in_opcode = 3'((k + 1) % 8);
            #1;
            checks++;
            if (bus.out_opcode !== 3'(k % 8) || bus.out_valid !== 1'b1 || count !== 3'd1) begin
                errors++;
                $display("FAIL b2b%0d: opcode=%b valid=%b count=%0d, want %b 1 1",
                         k, bus.out_opcode, bus.out_valid, count, 3'(k % 8));
            end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_opcode !== 3'd2 || count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_last: opcode=%b count=%0d, want 010 1", bus.out_opcode, count);
        end
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_opcode !== 3'd2) begin
            errors++;
            $display("FAIL b2b_drain: count=%0d valid=%b opcode=%b, want 0 0 010",
                     count, bus.out_valid, bus.out_opcode);
        end
    endtask

    task automatic test_flush();
        push_one(3'b101);
        push_one(3'b110);
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 3'b111;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_block: in_ready=%b want 0", bus.in_ready);
        end
        tick();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_opcode !== 3'b101 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: count=%0d valid=%b opcode=%b in_ready=%b, want 0 0 101 1",
                     count, bus.out_valid, bus.out_opcode, bus.in_ready);
        end
        push_one(3'b010);
        checks++;
        if (count !== 3'd1 || bus.out_opcode !== 3'b010) begin
            errors++;
            $display("FAIL flush_after: count=%0d head=%b, want 1 010", count, bus.out_opcode);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        push_one(3'b001);
        push_one(3'b010);
        push_one(3'b011);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_opcode !== 3'b000 || count !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b opcode=%b count=%0d, want 0 000 0",
                     bus.out_valid, bus.out_opcode, count);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        push_one(3'b110);
        checks++;
        if (count !== 3'd1 || bus.out_opcode !== 3'b110 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_after: count=%0d opcode=%b valid=%b, want 1 110 1",
                     count, bus.out_opcode, bus.out_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle();
        test_fifo_order();
        test_full();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
